// File: rtl/cash_register_v2.sv
// cash_register_v2: edge-triggered cash register with running sum, item count and total display.
// Optional macro CASH_REG_SAT_EN: saturate the sum on add overflow instead of wrapping.
module cash_register_v2 #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         i_clock,
    input  logic         i_resetn,
    input  logic         i_a,
    input  logic         i_v,
    input  logic         i_t,
    input  logic         i_c,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_total,
    output logic [N-1:0] o_count,
    output logic         o_ovf,
    output logic         o_err,
    output logic         o_disp
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ADD, S_SUB, S_MORE, S_LOADT, S_DISP, S_CLR
    } state_t;

    state_t       r_state, w_next;
    logic [3:0]   r_smp, r_prev, w_ev;
    logic         w_ev_c, w_ev_t, w_ev_v, w_ev_a;
    logic         w_add_bad, w_void_bad, w_err, r_sub, w_sub;
    logic [W-1:0] r_sum, r_opnd, w_sum_new;
    logic [W:0]   w_sum_add;

    // history bits ordered {C, T, V, A}; an event is a fresh rising sample
    assign w_ev   = r_smp & ~r_prev;
    assign w_ev_c = w_ev[3];
    assign w_ev_t = w_ev[2] & ~w_ev[3];
    assign w_ev_v = w_ev[1] & ~|w_ev[3:2];
    assign w_ev_a = w_ev[0] & ~|w_ev[3:1];

    assign w_add_bad  = &o_count;
    assign w_void_bad = (o_count == '0) || (i_x > r_sum);
    assign w_sum_add  = {1'b0, r_sum} + {1'b0, r_opnd};
`ifdef CASH_REG_SAT_EN
    assign w_sum_new  = w_sum_add[W] ? '1 : w_sum_add[W-1:0];
`else
    assign w_sum_new  = w_sum_add[W-1:0];
`endif
    assign o_disp = (r_state == S_DISP);

    always_comb begin
        w_next = r_state;
        w_sub  = r_sub;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: if (w_ev_a) begin
                w_err  = w_add_bad;
                w_next = w_add_bad ? S_IDLE : S_LOAD;
                w_sub  = 1'b0;
            end
            S_MORE: begin
                if (w_ev_c) w_next = S_CLR;
                else if (w_ev_t) w_next = S_LOADT;
                else if (w_ev_v || w_ev_a) begin
                    w_err  = w_ev_v ? w_void_bad : w_add_bad;
                    w_next = w_err ? S_MORE : S_LOAD;
                    w_sub  = w_ev_v;
                end
            end
            S_LOAD:       w_next = r_sub ? S_SUB : S_ADD;
            S_ADD, S_SUB: w_next = S_MORE;
            S_LOADT:      w_next = S_DISP;
            S_DISP:       if (w_ev_c) w_next = S_CLR;
            S_CLR:        w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
            r_smp   <= '1;
            r_prev  <= '1;
            r_sub   <= 1'b0;
            r_sum   <= '0;
            r_opnd  <= '0;
            o_total <= '0;
            o_count <= '0;
            o_ovf   <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_smp   <= {i_c, i_t, i_v, i_a};
            r_prev  <= r_smp;
            r_sub   <= w_sub;
            o_err   <= w_err;
            case (r_state)
                S_LOAD: r_opnd <= i_x;
                S_ADD: begin
                    r_sum   <= w_sum_new;
                    o_count <= o_count + 1'b1;
                    o_ovf   <= o_ovf | w_sum_add[W];
                end
                S_SUB: begin
                    r_sum   <= r_sum - r_opnd;
                    o_count <= o_count - 1'b1;
                end
                S_LOADT: o_total <= r_sum;
                S_CLR: begin
                    r_sum   <= '0;
                    r_opnd  <= '0;
                    o_total <= '0;
                    o_count <= '0;
                    o_ovf   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cash_register_v2.sv
// tb_cash_register_v2: directed plus randomized checks of cash_register_v2 against a behavioural model.
module tb_cash_register_v2;
    logic       clk = 0;
    logic       resetn, a, v, t, c;
    logic [7:0] x;
    logic [7:0] o_total;
    logic [3:0] o_count;
    logic       o_ovf, o_err, o_disp;

    logic       b_resetn, b_a, b_v, b_zero;
    logic [7:0] b_x, b_total;
    logic [1:0] b_count;
    logic       b_ovf, b_err, b_disp;

    int n_total = 0, n_bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    cash_register_v2 #(.W(8), .N(4)) dut (
        .i_clock(clk), .i_resetn(resetn), .i_a(a), .i_v(v), .i_t(t), .i_c(c), .i_x(x),
        .o_total(o_total), .o_count(o_count), .o_ovf(o_ovf), .o_err(o_err), .o_disp(o_disp));

    cash_register_v2 #(.W(8), .N(2)) dut_n2 (
        .i_clock(clk), .i_resetn(b_resetn), .i_a(b_a), .i_v(b_v), .i_t(b_zero), .i_c(b_zero), .i_x(b_x),
        .o_total(b_total), .o_count(b_count), .o_ovf(b_ovf), .o_err(b_err), .o_disp(b_disp));

    // Behavioural model: a command accepted on an edge occupies the register for a fixed
    // number of edges (add/void: capture price then apply; total/clear: apply next edge).
    localparam int ADD = 0, SUB = 1, TOT = 2, CLR = 3;
    int m_sum, m_opnd, m_total, m_count, m_ovf, m_err, m_busy, m_job, m_stat, top;
    logic [3:0] m_s, m_p, ev;

    always @(posedge clk) begin
        if (!resetn) begin
            m_sum = 0; m_opnd = 0; m_total = 0; m_count = 0; m_ovf = 0; m_err = 0;
            m_busy = 0; m_job = 0; m_stat = 0; m_s = 4'hf; m_p = 4'hf;
        end else begin
            ev = m_s & ~m_p;
            m_err = 0;
            if (m_busy == 2) begin
                m_opnd = int'(x);
                m_busy = 1;
            end else if (m_busy == 1) begin
                m_busy = 0;
                if (m_job == ADD) begin
                    m_sum = m_sum + m_opnd;
                    m_count++;
                    m_stat = 1;
                    if (m_sum > 255) begin
                        m_ovf = 1;
`ifdef CASH_REG_SAT_EN
                        m_sum = 255;
`else
                        m_sum = m_sum - 256;
`endif
                    end
                end else if (m_job == SUB) begin
                    m_sum = (m_sum - m_opnd + 256) % 256;
                    m_count--;
                    m_stat = 1;
                end else if (m_job == TOT) begin
                    m_total = m_sum;
                    m_stat = 2;
                end else begin
                    m_sum = 0; m_opnd = 0; m_total = 0; m_count = 0; m_ovf = 0; m_stat = 0;
                end
            end else begin
                top = ev[3] ? CLR : ev[2] ? TOT : ev[1] ? SUB : ev[0] ? ADD : -1;
                if ((m_stat == 0 || m_stat == 1) && top == ADD) begin
                    if (m_count == 15) m_err = 1;
                    else begin m_job = ADD; m_busy = 2; end
                end else if (m_stat == 1 && top == SUB) begin
                    if (m_count == 0 || int'(x) > m_sum) m_err = 1;
                    else begin m_job = SUB; m_busy = 2; end
                end else if (m_stat == 1 && top == TOT) begin
                    m_job = TOT; m_busy = 1;
                end else if (m_stat != 0 && top == CLR) begin
                    m_job = CLR; m_busy = 1;
                end
            end
            m_p = m_s;
            m_s = {c, t, v, a};
        end
    end

    always @(negedge clk) if (chk_en) begin
        n_total++;
        if (int'(o_total) != m_total || int'(o_count) != m_count || int'(o_ovf) != m_ovf ||
            int'(o_err) != m_err || int'(o_disp) != int'(m_stat == 2 && m_busy == 0)) begin
            n_bad++;
            $display("FAIL model t=%0t total=%0d/%0d count=%0d/%0d ovf=%0d/%0d err=%0d/%0d disp=%0d/%0d",
                     $time, o_total, m_total, o_count, m_count, o_ovf, m_ovf, o_err, m_err,
                     o_disp, m_stat == 2 && m_busy == 0);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic rst();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        @(posedge clk);
        #1;
    endtask

    // mask is {C, T, V, A}; returns how many cycles Err was high afterwards
    task automatic cmd(input logic [3:0] m, input logic [7:0] xv, output int errs);
        {c, t, v, a} = m;
        x = xv;
        @(posedge clk);
        #1 {c, t, v, a} = 4'b0;
        errs = 0;
        repeat (6) begin
            @(posedge clk);
            #1 errs = errs + int'(o_err);
        end
    endtask

    task automatic bpress(input logic isv, output int errs);
        {b_v, b_a} = isv ? 2'b10 : 2'b01;
        @(posedge clk);
        #1 {b_v, b_a} = 2'b00;
        errs = 0;
        repeat (6) begin
            @(posedge clk);
            #1 errs = errs + int'(b_err);
        end
    endtask

    initial begin
        int e, r;
        {a, v, t, c} = 4'b0;
        x = 0;
        resetn = 0;
        b_resetn = 0; b_a = 0; b_v = 0; b_zero = 0; b_x = 8'd1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        chk("rst_total", o_total, 0);
        chk("rst_count", o_count, 0);
        chk("rst_disp", o_disp, 0);
        rst();

        cmd(4'b0001, 8'd100, e);
        cmd(4'b0001, 8'd50, e);
        cmd(4'b0100, 8'd0, e);
        chk("sale_total", o_total, 150);
        chk("sale_count", o_count, 2);
        chk("sale_disp", o_disp, 1);
        chk("sale_ovf", o_ovf, 0);
        cmd(4'b1000, 8'd0, e);
        chk("clr_total", o_total, 0);
        chk("clr_count", o_count, 0);
        chk("clr_disp", o_disp, 0);

        cmd(4'b0001, 8'd200, e);
        cmd(4'b0001, 8'd100, e);
        cmd(4'b0100, 8'd0, e);
`ifdef CASH_REG_SAT_EN
        chk("ovf_total", o_total, 255);
`else
        chk("ovf_total", o_total, 44);
`endif
        chk("ovf_flag", o_ovf, 1);
        cmd(4'b1000, 8'd0, e);
        chk("ovf_clr", o_ovf, 0);

        cmd(4'b0001, 8'd30, e);
        cmd(4'b0001, 8'd20, e);
        cmd(4'b0010, 8'd20, e);
        chk("void_ok_err", e, 0);
        cmd(4'b0010, 8'd40, e);
        chk("void_big_err", e, 1);
        cmd(4'b0100, 8'd0, e);
        chk("void_total", o_total, 30);
        chk("void_count", o_count, 1);
        cmd(4'b1000, 8'd0, e);

        a = 1; x = 8'd7;
        repeat (10) @(posedge clk);
        #1 a = 0;
        repeat (5) @(posedge clk);
        #1 chk("hold_count", o_count, 1);
        cmd(4'b0101, 8'd7, e);
        chk("ta_total", o_total, 7);
        chk("ta_count", o_count, 1);
        chk("ta_disp", o_disp, 1);
        cmd(4'b1000, 8'd0, e);

        b_resetn = 1;
        @(posedge clk);
        #1;
        repeat (3) bpress(1'b0, e);
        chk("n2_count3", b_count, 3);
        bpress(1'b0, e);
        chk("n2_full_err", e, 1);
        chk("n2_full_count", b_count, 3);
        bpress(1'b1, e);
        chk("n2_void_count", b_count, 2);
        b_a = 1;
        @(posedge clk);
        #1 b_a = 0;
        @(posedge clk);
        @(posedge clk);
        #1 b_resetn = 0;
        @(posedge clk);
        #1 chk("n2_rst_count", b_count, 0);
        chk("n2_rst_outs", {b_total, b_ovf, b_err, b_disp}, 0);
        b_resetn = 1;
        @(posedge clk);
        #1 bpress(1'b0, e);
        chk("n2_idle_add", b_count, 1);

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) c = ~c;
            else if (r < 9) t = ~t;
            else if (r < 22) v = ~v;
            else if (r < 40) a = ~a;
            if ($urandom_range(0, 3) == 0)
                x = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            resetn = ($urandom_range(0, 299) != 0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
